// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared operation encodings, FSM states and default width for
//               the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Low two bits of the MULT/MULTU/DIV/DIVU funct codes (0x18..0x1B).
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One combinational shift-add (multiply) or restoring
//               shift-subtract (divide) iteration on a 2*XLEN accumulator.
//               The divide path exists only when MDU_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step #(
    parameter int XLEN = 32
) (
`ifdef MDU_DIV_EN
    input  logic              i_div,
`endif
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_m,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN:0] w_sum;
`ifdef MDU_DIV_EN
    logic [XLEN:0] w_rem;
    logic [XLEN:0] w_diff;
`endif

    always_comb begin
        // Multiply: add multiplicand into the upper half when the LSB is set,
        // then shift right keeping the carry.
        w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_m} : '0);
        o_acc = {w_sum, i_acc[XLEN-1:1]};
`ifdef MDU_DIV_EN
        w_rem  = i_acc[2*XLEN-1:XLEN-1];
        w_diff = w_rem - {1'b0, i_m};
        if (i_div) begin
            if (!w_diff[XLEN]) begin
                o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            end else begin
                o_acc = {w_rem[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//               Divide support is built only when MDU_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic [1:0]      Op,
    input  logic [XLEN-1:0] Rs,
    input  logic [XLEN-1:0] Rt,
    input  logic            MtHi,
    input  logic            MtLo,
    input  logic [XLEN-1:0] MtData,
    output logic [XLEN-1:0] Hi,
    output logic [XLEN-1:0] Lo,
    output logic            Busy,
    output logic            Done
);

    localparam int            CW          = $clog2(XLEN);
    localparam logic [CW-1:0] c_LAST_ITER = CW'(XLEN - 1);

    mdu_state_e          r_state;
    mdu_state_e          w_next;
    mdu_state_e          w_start_state;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   w_step_acc;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_m;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     w_res_hi;
    logic [XLEN-1:0]     w_res_lo;
    logic                r_uns;
    logic                r_neg;
`ifdef MDU_DIV_EN
    logic                r_div;
    logic                r_rneg;
`endif

    logic                w_idle_like;
    logic                w_accept;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept    = Start && w_idle_like;
    assign w_sa        = !r_uns && r_a[XLEN-1];
    assign w_sb        = !r_uns && r_b[XLEN-1];
    assign w_abs_a     = w_sa ? -r_a : r_a;
    assign w_abs_b     = w_sb ? -r_b : r_b;

`ifdef MDU_DIV_EN
    assign w_start_state = S_PREP;
`else
    // Without a divider, DIV/DIVU complete immediately with a zero result.
    assign w_start_state = Op[1] ? S_DONE : S_PREP;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (r_state)
            S_IDLE: if (Start) w_next = w_start_state;
            S_PREP: w_next = S_RUN;
            S_RUN:  if (r_cnt == c_LAST_ITER) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = Start ? w_start_state : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        Busy = (r_state == S_PREP) || (r_state == S_RUN) || (r_state == S_FIX);
        Done = (r_state == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_m   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_uns <= 1'b0;
            r_neg <= 1'b0;
`ifdef MDU_DIV_EN
            r_div  <= 1'b0;
            r_rneg <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_a   <= Rs;
                r_b   <= Rt;
                r_uns <= Op[0];
`ifdef MDU_DIV_EN
                r_div <= Op[1];
`endif
            end
            case (r_state)
                S_PREP: begin
                    r_cnt <= '0;
`ifdef MDU_DIV_EN
                    if (r_div) begin
                        r_m    <= w_abs_b;
                        r_acc  <= {{XLEN{1'b0}}, w_abs_a};
                        // A zero divisor keeps the all-ones quotient unsigned.
                        r_neg  <= (w_sa ^ w_sb) && (r_b != '0);
                        r_rneg <= w_sa;
                    end else begin
                        r_m   <= w_abs_a;
                        r_acc <= {{XLEN{1'b0}}, w_abs_b};
                        r_neg <= w_sa ^ w_sb;
                    end
`else
                    r_m   <= w_abs_a;
                    r_acc <= {{XLEN{1'b0}}, w_abs_b};
                    r_neg <= w_sa ^ w_sb;
`endif
                end
                S_RUN: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    mdu_step #(
        .XLEN  (XLEN)
    ) u_step (
`ifdef MDU_DIV_EN
        .i_div (r_div),
`endif
        .i_acc (r_acc),
        .i_m   (r_m),
        .o_acc (w_step_acc)
    );

    always_comb begin
        w_prod   = r_neg ? -r_acc : r_acc;
        w_res_hi = w_prod[2*XLEN-1:XLEN];
        w_res_lo = w_prod[XLEN-1:0];
`ifdef MDU_DIV_EN
        if (r_div) begin
            w_res_hi = r_rneg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
            w_res_lo = r_neg  ? -r_acc[XLEN-1:0]      : r_acc[XLEN-1:0];
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == S_FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
`ifndef MDU_DIV_EN
        end else if (w_accept && Op[1]) begin
            r_hi <= '0;
            r_lo <= '0;
`endif
        end else if (w_idle_like && !Start) begin
            if (MtHi) r_hi <= MtData;
            if (MtLo) r_lo <= MtData;
        end
    end

    assign Hi = r_hi;
    assign Lo = r_lo;

endmodule
`default_nettype wire
